// File: rtl/debug_mem_arb_if.sv
// Bus bundle for debug_mem_arb: debug requester, CPU requester and shared memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface debug_mem_arb_if;
    logic        d_valid;
    logic        d_ready;
    logic [3:0]  d_wstb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_except;

    logic        c_valid;
    logic        c_ready;
    logic [3:0]  c_wstb;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_except;

    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_wstb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_error;

    modport slave (
        input  d_valid, d_wstb, d_addr, d_wdata,
        output d_ready, d_rdata, d_except,
        input  c_valid, c_wstb, c_addr, c_wdata,
        output c_ready, c_rdata, c_except,
        output m_valid, m_wstb, m_addr, m_wdata,
        input  m_ready, m_rdata, m_error
    );

    modport master (
        output d_valid, d_wstb, d_addr, d_wdata,
        input  d_ready, d_rdata, d_except,
        output c_valid, c_wstb, c_addr, c_wdata,
        input  c_ready, c_rdata, c_except,
        input  m_valid, m_wstb, m_addr, m_wdata,
        output m_ready, m_rdata, m_error
    );
endinterface

// File: rtl/debug_mem_arb.sv
// Round-robin arbiter sharing one memory port between a debug and a CPU requester,
// with debug alignment checking and a memory-response timeout.
module debug_mem_arb #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic             clk,
    input logic             rst_n,
    debug_mem_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic        OWN_C    = 1'b0;
    localparam logic        OWN_D    = 1'b1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    logic        owner_r;
    logic        last_r;
    logic        is_write_r;
    logic [15:0] cnt_r;

    logic        grant_d_s;
    logic        grant_c_s;
    logic        d_illegal_s;

    // Access shapes the debug bus cannot express for the given address alignment.
    function automatic logic dbg_misaligned(input logic [3:0] wstb, input logic [1:0] lsb);
        logic bad;
        case (wstb)
            4'b0000, 4'b1111:                   bad = (lsb != 2'b00);
            4'b0011, 4'b1100:                   bad = lsb[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Grant selection: on a tie the port that did not win last time goes first.
    always_comb begin
        grant_d_s   = 1'b0;
        grant_c_s   = 1'b0;
        d_illegal_s = dbg_misaligned(bus.d_wstb, bus.d_addr[1:0]);
        if (bus.d_valid && bus.c_valid) begin
            if (last_r == OWN_C) begin
                grant_d_s = 1'b1;
            end else begin
                grant_c_s = 1'b1;
            end
        end else if (bus.d_valid) begin
            grant_d_s = 1'b1;
        end else if (bus.c_valid) begin
            grant_c_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_c_s = 1'b0;
        end
    end

    // Arbitration FSM; every port output is driven from here as a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= OWN_C;
            last_r       <= OWN_C;
            is_write_r   <= 1'b0;
            cnt_r        <= 16'd0;
            bus.m_valid  <= 1'b0;
            bus.m_wstb   <= 4'd0;
            bus.m_addr   <= 32'd0;
            bus.m_wdata  <= 32'd0;
            bus.d_ready  <= 1'b0;
            bus.d_rdata  <= 32'd0;
            bus.d_except <= 1'b0;
            bus.c_ready  <= 1'b0;
            bus.c_rdata  <= 32'd0;
            bus.c_except <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        owner_r <= OWN_D;
                        last_r  <= OWN_D;
                        if (d_illegal_s) begin
                            state_r      <= DONE;
                            bus.d_ready  <= 1'b1;
                            bus.d_except <= 1'b1;
                            bus.d_rdata  <= 32'd0;
                        end else begin
                            state_r     <= REQ;
                            cnt_r       <= 16'd0;
                            is_write_r  <= (bus.d_wstb != 4'b0000);
                            bus.m_valid <= 1'b1;
                            bus.m_wstb  <= bus.d_wstb;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                        end
                    end else if (grant_c_s) begin
                        owner_r     <= OWN_C;
                        last_r      <= OWN_C;
                        state_r     <= REQ;
                        cnt_r       <= 16'd0;
                        is_write_r  <= (bus.c_wstb != 4'b0000);
                        bus.m_valid <= 1'b1;
                        bus.m_wstb  <= bus.c_wstb;
                        bus.m_addr  <= bus.c_addr;
                        bus.m_wdata <= bus.c_wdata;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // A response arriving on the timeout cycle still counts as a completion.
                    if (bus.m_ready) begin
                        state_r     <= DONE;
                        bus.m_valid <= 1'b0;
                        if (owner_r == OWN_D) begin
                            bus.d_ready  <= 1'b1;
                            bus.d_except <= bus.m_error;
                            bus.d_rdata  <= is_write_r ? 32'd0 : bus.m_rdata;
                        end else begin
                            bus.c_ready  <= 1'b1;
                            bus.c_except <= bus.m_error;
                            bus.c_rdata  <= is_write_r ? 32'd0 : bus.m_rdata;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= DONE;
                        bus.m_valid <= 1'b0;
                        if (owner_r == OWN_D) begin
                            bus.d_ready  <= 1'b1;
                            bus.d_except <= 1'b1;
                            bus.d_rdata  <= 32'd0;
                        end else begin
                            bus.c_ready  <= 1'b1;
                            bus.c_except <= 1'b1;
                            bus.c_rdata  <= 32'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    bus.d_ready  <= 1'b0;
                    bus.d_rdata  <= 32'd0;
                    bus.d_except <= 1'b0;
                    bus.c_ready  <= 1'b0;
                    bus.c_rdata  <= 32'd0;
                    bus.c_except <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    bus.m_valid  <= 1'b0;
                    bus.d_ready  <= 1'b0;
                    bus.d_rdata  <= 32'd0;
                    bus.d_except <= 1'b0;
                    bus.c_ready  <= 1'b0;
                    bus.c_rdata  <= 32'd0;
                    bus.c_except <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_mem_arb.sv
// Transaction-level bench for debug_mem_arb: directed scenarios plus random traffic,
// checked against a request/arbitration model and a latency-programmable memory.
module tb_debug_mem_arb;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    debug_mem_arb_if bus();

    debug_mem_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory behaviour requested by the current transaction.
    int          mem_lat   = 0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_err   = 1'b0;

    // Observations made by the memory model.
    int          run         = 0;
    int          mv_total    = 0;
    int          pay_changes = 0;
    logic [3:0]  cap_wstb;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    // Reference requester state.
    bit          pend_d = 1'b0;
    bit          pend_c = 1'b0;
    bit          last_d = 1'b0;
    logic [3:0]  pd_w, pc_w;
    logic [31:0] pd_a, pd_wd, pc_a, pc_wd;

    // Memory: answers after mem_lat extra cycles; outside a request it drives noise.
    always @(negedge clk) begin
        if (bus.m_valid) begin
            if (run == 0) begin
                cap_wstb  = bus.m_wstb;
                cap_addr  = bus.m_addr;
                cap_wdata = bus.m_wdata;
            end else if (bus.m_wstb !== cap_wstb || bus.m_addr !== cap_addr || bus.m_wdata !== cap_wdata) begin
                pay_changes++;
            end
            bus.m_ready = (run == mem_lat);
            bus.m_rdata = mem_rdata;
            bus.m_error = mem_err;
            run++;
            mv_total++;
        end else begin
            run = 0;
            bus.m_ready = 1'($urandom_range(0, 1));
            bus.m_rdata = $urandom;
            bus.m_error = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_illegal(input logic [3:0] w, input logic [31:0] a);
        case (w)
            4'b1111:          return a[1:0] != 2'b00;
            4'b0011, 4'b1100: return a[0] == 1'b1;
            4'b0101, 4'b0110, 4'b0111, 4'b1001,
            4'b1010, 4'b1011, 4'b1101, 4'b1110: return 1'b1;
            4'b0000:          return a[1:0] != 2'b00;
            default:          return 1'b0;
        endcase
    endfunction

    // One completed transaction. Starts right after the previous owner dropped VALID;
    // new requests are raised one cycle later so a re-requesting port is low for a cycle.
    task automatic txn(input bit nd, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                       input bit nc, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cwd,
                       input int lat, input logic [31:0] rd, input bit err);
        bit p0, bd, bc, win_d, ill, got, exp_ex;
        int gedge, exp_edge, exp_mv, edges, mv0, pc0;
        logic [3:0]  ww;
        logic [31:0] wa, wwd, exp_rd;
        nd = nd && !pend_d;
        nc = nc && !pend_c;
        p0 = pend_d || pend_c;
        bd = p0 ? pend_d : nd;
        bc = p0 ? pend_c : nc;
        if (!bd && !bc) return;
        win_d = bd && (!bc || !last_d);
        if (nd) begin pend_d = 1'b1; pd_w = dw; pd_a = da; pd_wd = dwd; end
        if (nc) begin pend_c = 1'b1; pc_w = cw; pc_a = ca; pc_wd = cwd; end
        ww  = win_d ? pd_w  : pc_w;
        wa  = win_d ? pd_a  : pc_a;
        wwd = win_d ? pd_wd : pc_wd;
        gedge = p0 ? 1 : 2;
        ill = win_d && tb_illegal(ww, wa);
        if (ill) begin
            exp_edge = gedge; exp_mv = 0; exp_rd = 32'd0; exp_ex = 1'b1;
        end else if (lat >= TO) begin
            exp_edge = gedge + TO; exp_mv = TO; exp_rd = 32'd0; exp_ex = 1'b1;
        end else begin
            exp_edge = gedge + lat + 1; exp_mv = lat + 1;
            exp_rd = (ww == 4'b0000) ? rd : 32'd0; exp_ex = err;
        end
        mem_lat = lat; mem_rdata = rd; mem_err = err;
        mv0 = mv_total; pc0 = pay_changes;
        edges = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            if (edges == 1) begin
                #1;
                if (nd) begin bus.d_valid = 1'b1; bus.d_wstb = dw; bus.d_addr = da; bus.d_wdata = dwd; end
                if (nc) begin bus.c_valid = 1'b1; bus.c_wstb = cw; bus.c_addr = ca; bus.c_wdata = cwd; end
            end
            @(negedge clk);
            if (bus.d_ready || bus.c_ready) got = 1'b1;
            else check("except_outside_done", {30'd0, bus.d_except, bus.c_except}, 32'd0);
        end
        check("ready_seen", 32'(got), 32'd1);
        check("latency_edges", 32'(edges), 32'(exp_edge));
        check("owner_ready", 32'(win_d ? bus.d_ready : bus.c_ready), 32'd1);
        check("other_ready", 32'(win_d ? bus.c_ready : bus.d_ready), 32'd0);
        check("other_rdata", win_d ? bus.c_rdata : bus.d_rdata, 32'd0);
        check("other_except", 32'(win_d ? bus.c_except : bus.d_except), 32'd0);
        check("owner_rdata", win_d ? bus.d_rdata : bus.c_rdata, exp_rd);
        check("owner_except", 32'(win_d ? bus.d_except : bus.c_except), 32'(exp_ex));
        check("m_valid_cycles", 32'(mv_total - mv0), 32'(exp_mv));
        check("m_payload_stable", 32'(pay_changes - pc0), 32'd0);
        if (exp_mv > 0) begin
            check("m_wstb", {28'd0, cap_wstb}, {28'd0, ww});
            check("m_addr", cap_addr, wa);
            check("m_wdata", cap_wdata, wwd);
        end
        last_d = win_d;
        if (win_d) pend_d = 1'b0; else pend_c = 1'b0;
        @(posedge clk);
        #1;
        check("ready_one_cycle", {30'd0, bus.d_ready, bus.c_ready}, 32'd0);
        if (win_d) bus.d_valid = 1'b0; else bus.c_valid = 1'b0;
    endtask

    initial begin
        bit nd, nc;
        bus.d_valid = 1'b0; bus.d_wstb = 4'd0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus.c_valid = 1'b0; bus.c_wstb = 4'd0; bus.c_addr = 32'd0; bus.c_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m", {27'd0, bus.m_valid, bus.m_wstb}, 32'd0);
        check("reset_m_addr", bus.m_addr, 32'd0);
        check("reset_ready_except", {28'd0, bus.d_ready, bus.d_except, bus.c_ready, bus.c_except}, 32'd0);
        check("reset_rdata", bus.d_rdata | bus.c_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Debug read, immediate memory response.
        txn(1'b1, 4'b0000, 32'h8000_0000, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        // Misaligned word write, misaligned read, illegal strobe pattern.
        txn(1'b1, 4'b1111, 32'h0000_0002, 32'h1234_5678, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'h5555_5555, 1'b0);
        txn(1'b1, 4'b0000, 32'h0000_0101, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'h5555_5555, 1'b0);
        txn(1'b1, 4'b0101, 32'h0000_0100, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'h5555_5555, 1'b0);
        // Legal upper-halfword write and a write answered with an error.
        txn(1'b1, 4'b1100, 32'h0000_0202, 32'hCAFE_0000, 1'b0, 4'd0, 32'd0, 32'd0, 2, 32'h1111_1111, 1'b0);
        txn(1'b1, 4'b1111, 32'h0000_0010, 32'hA5A5_A5A5, 1'b0, 4'd0, 32'd0, 32'd0, 1, 32'hAAAA_AAAA, 1'b1);
        // CPU: misaligned read is not checked; timeout; recovery; response on the timeout cycle.
        txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 32'h0000_0003, 32'd0, 0, 32'h0BAD_F00D, 1'b0);
        txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 32'h0000_1000, 32'd0, 20, 32'h7777_7777, 1'b0);
        txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 32'h0000_1004, 32'd0, 2, 32'h1357_9BDF, 1'b0);
        txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 32'h0000_1008, 32'd0, TO - 1, 32'h2468_ACE0, 1'b0);
        // Both ports contending and re-requesting: grants alternate.
        txn(1'b1, 4'b0000, 32'h0000_0040, 32'd0, 1'b1, 4'b0000, 32'h0000_0080, 32'd0, 0, 32'h0000_00D1, 1'b0);
        txn(1'b1, 4'b0000, 32'h0000_0044, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'h0000_00C1, 1'b0);
        txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 32'h0000_0084, 32'd0, 0, 32'h0000_00D2, 1'b0);
        txn(1'b1, 4'b0000, 32'h0000_0048, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'h0000_00C2, 1'b0);
        txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 32'h0000_00D3, 1'b0);

        // Reset in the middle of a CPU request.
        mem_lat = 1000;
        bus.c_valid = 1'b1; bus.c_wstb = 4'b0000; bus.c_addr = 32'h0000_2000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_m_valid", 32'(bus.m_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_m", {27'd0, bus.m_valid, bus.m_wstb}, 32'd0);
        check("abort_m_addr", bus.m_addr, 32'd0);
        check("abort_ready_except", {28'd0, bus.d_ready, bus.d_except, bus.c_ready, bus.c_except}, 32'd0);
        bus.c_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {29'd0, bus.d_ready, bus.c_ready, bus.m_valid}, 32'd0);
        end
        last_d = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            nd = 1'($urandom_range(0, 1));
            nc = 1'($urandom_range(0, 1));
            if (!pend_d && !pend_c && !nd && !nc) nd = 1'b1;
            txn(nd, 4'($urandom_range(0, 15)), $urandom, $urandom,
                nc, 4'($urandom_range(0, 15)), $urandom, $urandom,
                $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 3) == 0));
        end
        while (pend_d || pend_c) begin
            txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1, $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
